vblank_update_scheduler: RTL and testbench
==========================================

# vblank_update_scheduler

Sequences game-state updaters (ball physics, blobby players, score) into the vertical blanking interval of the 1024x768@60 VGA timing chain. On each start of vblank it latches the pending update requests and grants exclusive access to the shared game-state registers to one requester at a time, in fixed priority order. Every write therefore lands between frames, and the drawing pipeline never sees a half-updated scene. Sits beside vga_timing in the 65 MHz pclk domain; its vblnk input is the same vblnk fed to the draw chain.

## Interface
- N_REQ, 4: number of requesters; index 0 has highest priority.
- TIMEOUT, 4096: maximum grant length in pclk cycles; range 2..65535.
- pclk  input  1  65 MHz pixel clock; all logic on its rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- vblnk  input  1  vertical blank from vga_timing.
- req  input  N_REQ  level request per updater; sampled only at frame start.
- done  input  N_REQ  updater finished; only the granted bit is honoured.
- grant  output  N_REQ  one-hot or zero; bit i is exclusive permission for updater i.
- frame_tick  output  1  one-cycle pulse on the cycle after the vblnk rising edge.
- busy  output  1  high whenever state is not IDLE.
- timeout_err  output  1  sticky until the next frame_tick; set when any grant times out.
- overrun_err  output  1  sticky until the next frame_tick; set when vblnk falls while work is pending or a grant is active.
- frame_cnt  output  16  count of frame_ticks; wraps 0xFFFF -> 0x0000.

## Operation
- vblnk is registered once (vblnk_q). The rise is detected as vblnk & ~vblnk_q and the fall as ~vblnk & vblnk_q.
- States are IDLE, ARM, GRANT and GAP.
- IDLE: on a rise, pending <= req, state <= ARM, frame_tick = 1, frame_cnt += 1, and both error flags clear.
- ARM: if pending == 0, go to IDLE. Otherwise sel <= index of the lowest set bit in pending, tmo_cnt <= 0, and go to GRANT.
- GRANT: grant = onehot(sel).
  - If done[sel] = 1: clear pending[sel] and go to GAP.
  - Else if tmo_cnt == TIMEOUT-1: clear pending[sel], set timeout_err, and go to GAP.
  - Otherwise increment tmo_cnt.
- GAP: one cycle with grant = 0, then go to ARM. Ownership never switches back-to-back.
- Done bits of non-granted requesters are ignored. Req changes after the rise have no effect until the next frame.
- A vblnk fall in any state other than IDLE sets overrun_err, clears pending, drops grant on the next cycle and forces IDLE. That fall cycle still follows the normal GRANT rules for done and timeout, but the next state is IDLE.
- A vblnk rise seen while not IDLE cannot occur with legal timing. If it does, it is ignored and frame_cnt does not increment.
- tmo_cnt width is clog2(TIMEOUT).
- Reset values: state IDLE, pending 0, grant 0, frame_tick 0, busy 0, both error flags 0, frame_cnt 0, vblnk_q 0.

## Timing
- Rise at cycle R, meaning vblnk is sampled high at R and vblnk_q is low. Then:
  - frame_tick and ARM are registered at R+1.
  - The first grant is asserted at R+2.
- done sampled high at cycle D deasserts grant at D+1 (GAP). The next grant, if any, asserts at D+3.
- A timed-out grant stays high for exactly TIMEOUT cycles.
- Fall sampled at cycle F: grant is low and overrun_err is high from F+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset mid-GRANT: assert rst_n = 0 while grant = 0001 -> grant, busy and pending are 0 immediately (asynchronous); after release, nothing is granted until the next vblnk rise.
- req = 1011, each updater returns done 5 cycles after its grant -> grants 0001, 0010, 1000 in order, each 5 cycles wide with a 2-cycle gap between. frame_tick pulses once. busy returns to 0 two cycles after the last done.
- req = 0100, done never asserted, TIMEOUT = 16 -> grant = 0100 for exactly 16 cycles, timeout_err = 1, then IDLE. The flag clears on the next frame_tick.
- Long updaters with the vblank shortened to 40 cycles -> on the cycle after the vblnk fall, grant = 0 and overrun_err = 1; remaining requesters get no grant that frame.
- done[2] pulsed while grant = 0001 -> no effect; grant 0001 holds until done[0].
- frame_cnt preloaded near wrap, 3 frames run -> FFFE, FFFF, 0000. req = 0000 -> frame_tick only, with no grant.

Source files
------------

// File: rtl/vblank_update_scheduler.sv
// Grants game-state updaters exclusive access to the shared registers, one at a time in
// fixed priority, within the vertical blanking interval so every write lands between frames.
//
// state | meaning
// IDLE  | waiting for the vblnk rise that starts a frame
// ARM   | pick the highest-priority pending requester, or finish the frame
// GRANT | one updater owns the game state until done or timeout
// GAP   | one dead cycle so ownership never switches back-to-back
module vblank_update_scheduler #(
    parameter int          N_REQ          = 4,
    parameter int          TIMEOUT        = 4096,
    parameter logic [15:0] FRAME_CNT_INIT = 16'h0000
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             vblnk,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] grant,
    output logic             frame_tick,
    output logic             busy,
    output logic             timeout_err,
    output logic             overrun_err,
    output logic [15:0]      frame_cnt
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [N_REQ-1:0] ONE_BIT  = N_REQ'(1);

    typedef enum logic [1:0] {IDLE, ARM, GRANT, GAP} state_t;

    state_t           state;
    logic             vblnk_q;
    logic [N_REQ-1:0] pending;
    logic [SW-1:0]    sel;
    logic [SW-1:0]    first_idx;
    logic [TW-1:0]    tmo_cnt;
    logic             rise;
    logic             fall;

    assign rise = vblnk & ~vblnk_q;
    assign fall = ~vblnk & vblnk_q;

    // Scan from the top so the lowest set bit (highest priority) wins.
    always_comb begin
        first_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pending[i]) first_idx = SW'(i);
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            vblnk_q     <= 1'b0;
            pending     <= '0;
            sel         <= '0;
            tmo_cnt     <= '0;
            grant       <= '0;
            frame_tick  <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
            frame_cnt   <= FRAME_CNT_INIT;
        end else begin
            vblnk_q    <= vblnk;
            frame_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        pending     <= req;
                        state       <= ARM;
                        busy        <= 1'b1;
                        frame_tick  <= 1'b1;
                        frame_cnt   <= frame_cnt + 16'd1;
                        timeout_err <= 1'b0;
                        overrun_err <= 1'b0;
                    end
                end
                ARM: begin
                    if (pending == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        sel     <= first_idx;
                        tmo_cnt <= '0;
                        grant   <= ONE_BIT << first_idx;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (done[sel]) begin
                        pending[sel] <= 1'b0;
                        grant        <= '0;
                        state        <= GAP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        pending[sel] <= 1'b0;
                        grant        <= '0;
                        timeout_err  <= 1'b1;
                        state        <= GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                GAP: state <= ARM;
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    grant <= '0;
                end
            endcase
            // Blanking ended with work outstanding: abandon the rest of the frame.
            if (fall && state != IDLE) begin
                overrun_err <= 1'b1;
                pending     <= '0;
                grant       <= '0;
                busy        <= 1'b0;
                state       <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Directed bench for vblank_update_scheduler: priority order, timeout, overrun,
// ignored done bits, asynchronous reset and frame counter wrap.
module tb_vblank_update_scheduler;
    logic        pclk = 1'b0;
    logic        rst_n;
    logic        vblnk;
    logic [3:0]  req;
    logic [3:0]  done;
    logic [3:0]  grant, grant_w;
    logic        frame_tick, frame_tick_w;
    logic        busy, busy_w;
    logic        timeout_err, timeout_err_w;
    logic        overrun_err, overrun_err_w;
    logic [15:0] frame_cnt, frame_cnt_w;
    int          checks = 0;
    int          errors = 0;

    vblank_update_scheduler #(.N_REQ(4), .TIMEOUT(16)) dut (
        .pclk(pclk), .rst_n(rst_n), .vblnk(vblnk), .req(req), .done(done),
        .grant(grant), .frame_tick(frame_tick), .busy(busy),
        .timeout_err(timeout_err), .overrun_err(overrun_err), .frame_cnt(frame_cnt)
    );

    // Second instance starts its frame counter just below the wrap point.
    vblank_update_scheduler #(.N_REQ(4), .TIMEOUT(16), .FRAME_CNT_INIT(16'hFFFD)) dut_w (
        .pclk(pclk), .rst_n(rst_n), .vblnk(vblnk), .req(req), .done(done),
        .grant(grant_w), .frame_tick(frame_tick_w), .busy(busy_w),
        .timeout_err(timeout_err_w), .overrun_err(overrun_err_w), .frame_cnt(frame_cnt_w)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Leaves the bench just after the edge that sampled the rise (t0).
    task automatic rise();
        vblnk = 1'b0;
        tick();
        vblnk = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vblnk = 1'b0; req = '0; done = '0;
        repeat (2) tick();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", frame_tick); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (timeout_err !== 1'b0 || overrun_err !== 1'b0) begin errors++; $display("FAIL reset_errs got %b%b want 00", timeout_err, overrun_err); end
        checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL reset_cnt got %h want 0000", frame_cnt); end
        checks++; if (frame_cnt_w !== 16'hFFFD) begin errors++; $display("FAIL reset_cnt_w got %h want fffd", frame_cnt_w); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_priority_order();
        logic [3:0] exp;
        req = 4'b1011;
        rise();
        checks++; if (frame_tick !== 1'b1 || grant !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL prio_t0 got tick=%b grant=%b busy=%b want 1 0000 1", frame_tick, grant, busy); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL prio_cnt got %0d want 1", frame_cnt); end
        for (int t = 1; t <= 22; t++) begin
            tick();
            done = '0;
            exp = (t >= 1 && t <= 5) ? 4'b0001 : (t >= 8 && t <= 12) ? 4'b0010 :
                  (t >= 15 && t <= 19) ? 4'b1000 : 4'b0000;
            checks++; if (grant !== exp) begin errors++; $display("FAIL prio_grant t=%0d got %b want %b", t, grant, exp); end
            checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL prio_tick t=%0d got %b want 0", t, frame_tick); end
            checks++; if (busy !== (t <= 21)) begin errors++; $display("FAIL prio_busy t=%0d got %b want %b", t, busy, (t <= 21)); end
            if (t == 5 || t == 12 || t == 19) done = exp;
        end
    endtask

    task automatic test_timeout();
        logic [3:0] exp;
        req = 4'b0100;
        rise();
        checks++; if (frame_tick !== 1'b1 || frame_cnt !== 16'd2) begin errors++; $display("FAIL tmo_t0 got tick=%b cnt=%0d want 1 2", frame_tick, frame_cnt); end
        for (int t = 1; t <= 19; t++) begin
            tick();
            exp = (t <= 16) ? 4'b0100 : 4'b0000;
            checks++; if (grant !== exp) begin errors++; $display("FAIL tmo_grant t=%0d got %b want %b", t, grant, exp); end
            checks++; if (timeout_err !== (t >= 17)) begin errors++; $display("FAIL tmo_flag t=%0d got %b want %b", t, timeout_err, (t >= 17)); end
            checks++; if (busy !== (t <= 18)) begin errors++; $display("FAIL tmo_busy t=%0d got %b want %b", t, busy, (t <= 18)); end
        end
        req = 4'b0000;
        rise();
        checks++; if (frame_tick !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_clear got tick=%b flag=%b want 1 0", frame_tick, timeout_err); end
        tick();
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL tmo_empty got grant=%b busy=%b want 0000 0", grant, busy); end
    endtask

    task automatic test_overrun();
        logic [3:0] exp;
        req = 4'b1111;
        rise();
        checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL ovr_cnt got %0d want 4", frame_cnt); end
        for (int t = 1; t <= 45; t++) begin
            tick();
            exp = (t <= 16) ? 4'b0001 : (t >= 19 && t <= 34) ? 4'b0010 :
                  (t >= 37 && t <= 39) ? 4'b0100 : 4'b0000;
            checks++; if (grant !== exp) begin errors++; $display("FAIL ovr_grant t=%0d got %b want %b", t, grant, exp); end
            checks++; if (overrun_err !== (t >= 40)) begin errors++; $display("FAIL ovr_flag t=%0d got %b want %b", t, overrun_err, (t >= 40)); end
            if (t == 40) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovr_busy got %b want 0", busy); end
            end
            if (t == 39) vblnk = 1'b0;
        end
    endtask

    task automatic test_done_ignored();
        logic [3:0] exp;
        req = 4'b0101;
        rise();
        checks++; if (overrun_err !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL ign_clear got ovr=%b tmo=%b want 0 0", overrun_err, timeout_err); end
        for (int t = 1; t <= 12; t++) begin
            tick();
            done = '0;
            exp = (t <= 6) ? 4'b0001 : (t == 9) ? 4'b0100 : 4'b0000;
            checks++; if (grant !== exp) begin errors++; $display("FAIL ign_grant t=%0d got %b want %b", t, grant, exp); end
            if (t == 2) done = 4'b0100;
            if (t == 6) done = 4'b0001;
            if (t == 9) done = 4'b0100;
        end
        checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL ign_end got busy=%b tmo=%b want 0 0", busy, timeout_err); end
    endtask

    task automatic test_reset_mid_grant();
        req = 4'b0001;
        rise();
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rstg_pre got %b want 0001", grant); end
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rstg_async got grant=%b busy=%b want 0000 0", grant, busy); end
        vblnk = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick();
            checks++; if (grant !== 4'b0000 || busy !== 1'b0 || frame_tick !== 1'b0) begin errors++; $display("FAIL rstg_quiet t=%0d got grant=%b busy=%b tick=%b want 0000 0 0", t, grant, busy, frame_tick); end
        end
        rise();
        checks++; if (frame_tick !== 1'b1 || frame_cnt !== 16'd1) begin errors++; $display("FAIL rstg_frame got tick=%b cnt=%0d want 1 1", frame_tick, frame_cnt); end
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rstg_regrant got %b want 0001", grant); end
        done = 4'b0001;
        tick();
        done = '0;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rstg_done got %b want 0000", grant); end
        repeat (2) tick();
    endtask

    task automatic test_frame_wrap();
        logic [15:0] exp_w [3];
        exp_w[0] = 16'hFFFE; exp_w[1] = 16'hFFFF; exp_w[2] = 16'h0000;
        rst_n = 1'b0; vblnk = 1'b0; req = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
        for (int f = 0; f < 3; f++) begin
            rise();
            checks++; if (frame_cnt_w !== exp_w[f]) begin errors++; $display("FAIL wrap_cnt f=%0d got %h want %h", f, frame_cnt_w, exp_w[f]); end
            checks++; if (frame_cnt !== 16'(f + 1)) begin errors++; $display("FAIL wrap_cnt0 f=%0d got %0d want %0d", f, frame_cnt, f + 1); end
            checks++; if (frame_tick_w !== 1'b1) begin errors++; $display("FAIL wrap_tick f=%0d got %b want 1", f, frame_tick_w); end
            tick();
            checks++; if (grant_w !== 4'b0000 || busy_w !== 1'b0 || frame_tick_w !== 1'b0) begin errors++; $display("FAIL wrap_idle f=%0d got grant=%b busy=%b tick=%b want 0000 0 0", f, grant_w, busy_w, frame_tick_w); end
        end
    endtask

    initial begin
        test_reset();
        test_priority_order();
        test_timeout();
        test_overrun();
        test_done_ignored();
        test_reset_mid_grant();
        test_frame_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
